// File: rtl/logic_clk_div_pkg.sv
// Shared types and helpers for the logic clock divider family.
// Holds the meter FSM encoding and the counter saturation limit.
package logic_clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meter_state_t;

    // All-ones value of a counter 'bits' wide, returned in a 64-bit container.
    function automatic logic [63:0] sat_limit(input int unsigned bits);
        if (bits >= 64) begin
            return '1;
        end
        return (64'd1 << bits) - 64'd1;
    endfunction

endpackage

// File: rtl/logic_sync_edge.sv
// Brings an asynchronous level into the clk domain and flags its rising edges.
// Shared between the clock divider and the frequency meter.
module logic_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   delay_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff  <= '0;
            delay_ff <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[SYNC_STAGES-2:0], async_in};
            delay_ff <= sync_ff[SYNC_STAGES-1];
            rise     <= sync_ff[SYNC_STAGES-1] & ~delay_ff;
        end
    end

endmodule

// File: rtl/logic_clk_freq_meter.sv
// Counts rising edges of the divided clock over a programmed gate window and
// tracks the shortest and longest edge-to-edge period seen in that window.
module logic_clk_freq_meter
    import logic_clk_div_pkg::*;
#(
    parameter int COUNTER_BITS = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    axi_clk,
    input  logic                    axi_resetn,
    input  logic                    meas_clk_in,
    input  logic                    start,
    input  logic [COUNTER_BITS-1:0] gate_cycles,
    output logic                    busy,
    output logic                    done,
    output logic [COUNTER_BITS-1:0] edge_count,
    output logic [COUNTER_BITS-1:0] period_min,
    output logic [COUNTER_BITS-1:0] period_max,
    output logic                    overflow,
    output logic                    no_edge
);

    localparam logic [63:0]             CNT_MAX_WIDE = sat_limit(COUNTER_BITS);
    localparam logic [COUNTER_BITS-1:0] CNT_MAX      = CNT_MAX_WIDE[COUNTER_BITS-1:0];

    logic                    rise;
    meter_state_t            state;
    logic [COUNTER_BITS-1:0] gate_len;
    logic [COUNTER_BITS-1:0] gate_cnt;
    logic [COUNTER_BITS-1:0] period_cnt;
    logic [COUNTER_BITS-1:0] edge_cnt;
    logic [COUNTER_BITS-1:0] min_work;
    logic [COUNTER_BITS-1:0] max_work;
    logic                    ovf_work;
    logic                    no_edge_work;
    logic                    gate_last;

    logic_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (axi_clk),
        .rst_n    (axi_resetn),
        .async_in (meas_clk_in),
        .rise     (rise)
    );

    assign gate_last = (gate_cnt == gate_len - 1'b1);

    // Working registers accumulate during the run; outputs only move in DONE
    // so software always reads a complete, coherent result set.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state        <= ST_IDLE;
            gate_len     <= '0;
            gate_cnt     <= '0;
            period_cnt   <= '0;
            edge_cnt     <= '0;
            min_work     <= '1;
            max_work     <= '0;
            ovf_work     <= 1'b0;
            no_edge_work <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            edge_count   <= '0;
            period_min   <= '1;
            period_max   <= '0;
            overflow     <= 1'b0;
            no_edge      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        gate_len     <= gate_cycles;
                        gate_cnt     <= '0;
                        period_cnt   <= '0;
                        edge_cnt     <= '0;
                        min_work     <= '1;
                        max_work     <= '0;
                        ovf_work     <= 1'b0;
                        no_edge_work <= 1'b0;
                        busy         <= 1'b1;
                        state        <= (gate_cycles == '0) ? ST_DONE : ST_ARM;
                    end
                end

                ST_ARM: begin
                    if (rise) begin
                        period_cnt <= {{(COUNTER_BITS-1){1'b0}}, 1'b1};
                        gate_cnt   <= '0;
                        state      <= ST_MEASURE;
                    end else if (gate_last) begin
                        no_edge_work <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                    end
                end

                ST_MEASURE: begin
                    gate_cnt <= gate_cnt + 1'b1;
                    if (rise) begin
                        if (edge_cnt == CNT_MAX) begin
                            ovf_work <= 1'b1;
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                        if (period_cnt < min_work) begin
                            min_work <= period_cnt;
                        end
                        if (period_cnt > max_work) begin
                            max_work <= period_cnt;
                        end
                        period_cnt <= {{(COUNTER_BITS-1){1'b0}}, 1'b1};
                    end else if (period_cnt == CNT_MAX) begin
                        ovf_work <= 1'b1;
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                    // An edge landing in the final window cycle is still counted above.
                    if (gate_last) begin
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    edge_count <= edge_cnt;
                    period_min <= min_work;
                    period_max <= max_work;
                    overflow   <= ovf_work;
                    no_edge    <= no_edge_work;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
